// File: rtl/grf_wb.sv
// grf_wb: 32-entry MIPS general register file with write-back port, $0 hardwired to zero.
// Latency: reads are combinational with same-cycle write bypass; writes commit on the rising clk edge.
// Backpressure: none; at most one write per cycle, always accepted. Optional GRF_TRACE_EN prints committed writes.
module grf_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [31:0]       pc,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  // A write actually lands only out of reset and to a non-zero register;
  // the same qualifier gates the bypass so reset also suppresses it.
  logic wr_fire;
  assign wr_fire = reset && we && (wa != '0);

  // Storage and retired-write counter; reset wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      wr_cnt <= '0;
    end else if (wr_fire) begin
      regs[wa] <= wd;
      wr_cnt   <= wr_cnt + CNT_W'(1);
    end
  end

  // Read port 1: $0 reads zero, otherwise bypass the in-flight write, else stored value.
  always_comb begin
    rd1 = regs[ra1];
    if (ra1 == '0) begin
      rd1 = '0;
    end else if (wr_fire && (ra1 == wa)) begin
      rd1 = wd;
    end
  end

  // Read port 2: same selection rules as port 1.
  always_comb begin
    rd2 = regs[ra2];
    if (ra2 == '0) begin
      rd2 = '0;
    end else if (wr_fire && (ra2 == wa)) begin
      rd2 = wd;
    end
  end

`ifdef GRF_TRACE_EN
  // Simulation-only trace of each committed write to a non-zero register.
  always @(posedge clk) begin
    if (wr_fire) begin
      $display("@%08h: $%0d%0d <= %08h", pc, wa / 10, wa % 10, wd);
    end
  end
`else
  // pc only feeds the trace; fold it into a sink so it is visibly consumed.
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_grf_wb.sv
// Directed bench for grf_wb: reset sweep, writes, $0 protection, bypass, reset/write collision, counting.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
// Every expected value below is a hand-computed constant.
module tb_grf_wb;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] pc;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] wr_cnt;

  int tests;
  int fails;

  grf_wb dut (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .wa     (wa),
    .wd     (wd),
    .pc     (pc),
    .ra1    (ra1),
    .ra2    (ra2),
    .rd1    (rd1),
    .rd2    (rd2),
    .wr_cnt (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    we    = 1'b0;
    wa    = '0;
    wd    = '0;
    pc    = '0;
    ra1   = '0;
    ra2   = '0;

    // 1. reset for two edges, release, sweep every address
    tick();
    tick();
    chk("reset_cnt_in_reset", wr_cnt, 32'h0);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #1;
      chk($sformatf("sweep_rd1_%0d", i), rd1, 32'h0);
      chk($sformatf("sweep_rd2_%0d", 31 - i), rd2, 32'h0);
    end
    chk("reset_cnt", wr_cnt, 32'h0);

    // 2. basic write
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    tick();
    we = 1'b0;
    ra1 = 5'd5; ra2 = 5'd6;
    #1;
    chk("basic_rd1", rd1, 32'hDEADBEEF);
    chk("basic_rd2_other", rd2, 32'h0);
    chk("basic_cnt", wr_cnt, 32'd1);

    // 3. $0 protection, including no same-cycle bypass
    we = 1'b1; wa = 5'd0; wd = 32'h12345678; ra1 = 5'd0; ra2 = 5'd0;
    #1;
    chk("zero_nobypass_rd1", rd1, 32'h0);
    chk("zero_nobypass_rd2", rd2, 32'h0);
    tick();
    we = 1'b0;
    #1;
    chk("zero_after_rd1", rd1, 32'h0);
    chk("zero_cnt", wr_cnt, 32'd1);

    // 4. bypass on both ports; an unrelated port still reads storage
    we = 1'b1; wa = 5'd7; wd = 32'h1;
    tick();
    chk("pre7_cnt", wr_cnt, 32'd2);
    wd = 32'hA5A5A5A5; ra1 = 5'd7; ra2 = 5'd7;
    #1;
    chk("bypass_rd1", rd1, 32'hA5A5A5A5);
    chk("bypass_rd2", rd2, 32'hA5A5A5A5);
    ra2 = 5'd5;
    #1;
    chk("bypass_other_rd2", rd2, 32'hDEADBEEF);
    tick();
    we = 1'b0; ra2 = 5'd7;
    #1;
    chk("post_bypass_rd1", rd1, 32'hA5A5A5A5);
    chk("post_bypass_rd2", rd2, 32'hA5A5A5A5);
    chk("post_bypass_cnt", wr_cnt, 32'd3);

    // disabled write leaves storage alone
    wa = 5'd7; wd = 32'hCAFEF00D;
    tick();
    chk("we0_rd1", rd1, 32'hA5A5A5A5);
    chk("we0_cnt", wr_cnt, 32'd3);

    // 5. reset vs write collision
    we = 1'b1; wa = 5'd3; wd = 32'hFF;
    tick();
    we = 1'b0; ra1 = 5'd3;
    #1;
    chk("pre_coll_rd1", rd1, 32'hFF);
    chk("pre_coll_cnt", wr_cnt, 32'd4);
    reset = 1'b0; we = 1'b1; wa = 5'd3; wd = 32'h77;
    #1;
    chk("coll_nobypass_rd1", rd1, 32'hFF);
    tick();
    reset = 1'b1; we = 1'b0; ra2 = 5'd5;
    #1;
    chk("coll_rd1", rd1, 32'h0);
    chk("coll_rd2_r5", rd2, 32'h0);
    chk("coll_cnt", wr_cnt, 32'h0);
    ra1 = 5'd7;
    #1;
    chk("coll_rd1_r7", rd1, 32'h0);

    // 6. two writes to $31, counter follows
    pc = 32'h00003000;
    we = 1'b1; wa = 5'd31; wd = 32'h00003008; ra1 = 5'd31; ra2 = 5'd31;
    tick();
    we = 1'b0;
    #1;
    chk("r31_first", rd1, 32'h00003008);
    chk("r31_first_cnt", wr_cnt, 32'd1);
    we = 1'b1; wd = 32'h0;
    tick();
    we = 1'b0;
    #1;
    chk("r31_second_rd1", rd1, 32'h0);
    chk("r31_second_rd2", rd2, 32'h0);
    chk("r31_cnt", wr_cnt, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
